// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: pc generation, single-outstanding imem request, decode handshake
//
// Ports:
//   i_clk, i_rst           clock; asynchronous active-high reset
//   i_flush, i_flush_pc    redirect request and target pc (highest priority)
//   o_post_valid           instruction slot valid towards decode
//   i_post_ready           decode accepts the slot
//   o_ifu_ins/pc/nop       slot instruction, its pc, bubble flag
//   o_imem_req/addr        memory request and address (address is the pc register)
//   i_imem_gnt             request accepted
//   i_imem_rvalid/rdata    response valid and instruction
//   i_imem_err             access fault, qualified by i_imem_rvalid
module ifu_fetch #(
    parameter int                   CPU_WIDTH = 64,
    parameter int                   INS_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 64'h8000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic [CPU_WIDTH-1:0] i_flush_pc,
    output logic                 o_post_valid,
    input  logic                 i_post_ready,
    output logic [INS_WIDTH-1:0] o_ifu_ins,
    output logic [CPU_WIDTH-1:0] o_ifu_pc,
    output logic                 o_ifu_nop,
    output logic                 o_imem_req,
    output logic [CPU_WIDTH-1:0] o_imem_addr,
    input  logic                 i_imem_gnt,
    input  logic                 i_imem_rvalid,
    input  logic [INS_WIDTH-1:0] i_imem_rdata,
    input  logic                 i_imem_err
);

    localparam logic [INS_WIDTH-1:0] NOP_INS = INS_WIDTH'(32'h13);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CPU_WIDTH-1:0]   pc_q, pc_d;
    logic                   kill_q, kill_d;
    logic                   valid_q, valid_d;
    logic [INS_WIDTH-1:0]   ins_q, ins_d;
    logic [CPU_WIDTH-1:0]   ipc_q, ipc_d;
    logic                   nop_q, nop_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            valid_q <= 1'b0;
            ins_q   <= NOP_INS;
            ipc_q   <= RESET_PC;
            nop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            valid_q <= valid_d;
            ins_q   <= ins_d;
            ipc_q   <= ipc_d;
            nop_q   <= nop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        valid_d = valid_q;
        ins_d   = ins_q;
        ipc_d   = ipc_q;
        nop_d   = nop_q;

        // Every redirect retargets the pc, whatever the state does next.
        if (i_flush) begin
            pc_d = i_flush_pc;
        end

        case (state_q)
            IDLE: begin
                // Responses left over from before reset are ignored here.
                state_d = REQ;
            end
            REQ: begin
                if (i_imem_gnt) begin
                    // A request granted on a flush cycle is for the old path.
                    if (i_flush) begin
                        kill_d = 1'b1;
                    end
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (i_flush) begin
                    if (i_imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (i_imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        ins_d   = i_imem_err ? NOP_INS : i_imem_rdata;
                        ipc_d   = pc_q;
                        nop_d   = i_imem_err;
                        valid_d = 1'b1;
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (i_flush) begin
                    // Decode drops its own copy on flush, so no +4 here.
                    valid_d = 1'b0;
                    state_d = REQ;
                end else if (i_post_ready) begin
                    pc_d    = pc_q + CPU_WIDTH'(4);
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_post_valid = valid_q;
    assign o_ifu_ins    = ins_q;
    assign o_ifu_pc     = ipc_q;
    assign o_ifu_nop    = nop_q;
    assign o_imem_req   = (state_q == REQ);
    assign o_imem_addr  = pc_q;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage that generates the PC, issues one instruction-memory request at a time, and registers the returned instruction.
- Presents the instruction to the decode stage through the pipeline valid/ready handshake, together with its pc and a nop flag.
- It is the upstream (producer) end of the decode stage's pre-stage interface: its o_post_valid / o_ifu_ins / o_ifu_pc / o_ifu_nop drive the decoder's valid / instruction / pc / nop inputs, and its i_post_ready is driven by the decoder's ready.
- Redirects (branch, jump, trap) arrive on i_flush with a target PC.

Parameters:
- CPU_WIDTH, 64, PC and address width.
- INS_WIDTH, 32, instruction width.
- RESET_PC, 64'h8000_0000, first fetch address after reset.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_flush  input  1  redirect request; has priority over every other event.
- i_flush_pc  input  CPU_WIDTH  redirect target, sampled when i_flush=1.
- o_post_valid  output  1  instruction slot valid to decode.
- i_post_ready  input  1  decode accepts the slot.
- o_ifu_ins  output  INS_WIDTH  fetched instruction.
- o_ifu_pc  output  CPU_WIDTH  pc of o_ifu_ins.
- o_ifu_nop  output  1  slot is a bubble; decode substitutes a nop instruction.
- o_imem_req  output  1  memory request.
- o_imem_addr  output  CPU_WIDTH  request address; always equals the current pc register.
- i_imem_gnt  input  1  request accepted this cycle.
- i_imem_rvalid  input  1  response valid.
- i_imem_rdata  input  INS_WIDTH  response instruction.
- i_imem_err  input  1  access fault, qualified by i_imem_rvalid.

Behaviour:
- Reset values (asynchronous on i_rst=1):
  - state=IDLE, pc=RESET_PC, kill=0.
  - o_post_valid=0, o_ifu_ins=32'h13, o_ifu_pc=RESET_PC, o_ifu_nop=0, o_imem_req=0.
- States:
  - IDLE: one cycle after reset deassertion, then go to REQ. i_imem_rvalid is ignored here.
  - REQ: o_imem_req=1, o_imem_addr=pc. On i_imem_gnt go to WAIT.
  - WAIT: o_imem_req=0. On i_imem_rvalid:
    - if kill=1: discard the response, clear kill, go to REQ.
    - otherwise: register o_ifu_ins=i_imem_rdata, o_ifu_pc=pc, o_ifu_nop=i_imem_err, set o_post_valid=1, go to OUT.
    - When i_imem_err=1, o_ifu_ins is forced to 32'h13.
  - OUT: o_post_valid=1; outputs are held stable while i_post_ready=0. On i_post_ready=1: pc<=pc+4, o_post_valid<=0, go to REQ.
- Latency: gnt in the REQ cycle plus rvalid on the next cycle gives o_post_valid 2 cycles after the REQ cycle began. Maximum throughput is one instruction per 3 cycles. Exactly one outstanding request at any time.
- Flush (i_flush=1), in every case pc<=i_flush_pc:
  - IDLE: no further effect.
  - REQ: stay in REQ; the address changes next cycle. If i_imem_gnt=1 in the same cycle, that request is in flight: set kill=1 and go to WAIT.
  - WAIT: set kill=1 and stay in WAIT. If i_imem_rvalid=1 in the same cycle, discard the response and go directly to REQ with kill=0.
  - OUT: o_post_valid<=0 and go to REQ, even if i_post_ready=1 in the same cycle (decode clears its own register on flush).
- Flush while kill=1 already: kill stays 1 and pc takes the newest target.
- pc arithmetic is modulo 2^CPU_WIDTH; wrap from all-ones-minus-3 to 0 is legal.
- No alignment check: pc[1:0] comes only from reset, +4, or the flush target. Flush targets are 4-byte aligned by contract.
- o_imem_addr is permitted to change while o_imem_req=1 only on a flush cycle.
- Reset mid-operation: state is dropped immediately. A memory response arriving after reset deassertion lands in IDLE and is ignored; the memory side is reset by the same i_rst.

Test Plan:
- Reset then idle memory (gnt=1 immediately, rvalid next cycle, rdata=32'h0000_0513), i_post_ready=1 → first o_post_valid with o_ifu_pc=0x8000_0000, o_ifu_ins=0x00000513, o_ifu_nop=0. Next slot has pc 0x8000_0004 exactly 3 cycles later.
- Backpressure: i_post_ready=0 for 5 cycles in OUT → o_post_valid, o_ifu_ins and o_ifu_pc stable, o_imem_req=0. Ready released → pc advances to +4.
- Flush in WAIT with target 0x8000_0100, stale rvalid 2 cycles later with rdata=32'hDEAD_BEEF → response discarded, next request address 0x8000_0100, no valid slot carries 0xDEADBEEF.
- Flush and rvalid in the same WAIT cycle → no slot emitted; REQ on the next cycle with o_imem_addr=flush target.
- Flush in OUT with i_post_ready=1 simultaneously → o_post_valid=0 the next cycle, pc=flush target, no +4 increment.
- i_imem_err=1 with rvalid at pc 0x8000_0008 → slot with o_ifu_nop=1, o_ifu_ins=0x13, o_ifu_pc=0x8000_0008.
- i_rst pulsed while in WAIT → outputs return to reset values asynchronously; after release, first request address is 0x8000_0000.
